data_check: RTL and testbench

// Receive-side frame checker for the 10-bit PRBS test frames (HEAD comma, PRBS_LENGTH PRBS words, TAIL comma).

---
 rtl/data_check.sv | 157 +++++++++++++++
 tb/tb_data_check.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_check.sv
// Receive-side checker for 10-bit PRBS test frames: HEAD comma, PRBS_LENGTH
// PRBS words, TAIL comma. Counts bit errors per frame and keeps frame totals.
module data_check #(
    parameter int unsigned             PRBS_LENGTH = 8,
    parameter logic [9:0]              COMMA       = 10'b1100110011,
    parameter int unsigned             POLY_LENGHT = 9,
    parameter int unsigned             POLY_TAP    = 5,
    parameter logic [POLY_LENGHT-1:0]  PRBS_SEED   = {POLY_LENGHT{1'b1}},
    parameter int unsigned             ERR_W       = 10,
    parameter int unsigned             CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             check_enable,
    input  logic [9:0]       data_in,
    output logic             in_frame,
    output logic             frame_done,
    output logic             frame_err,
    output logic             tail_err,
    output logic [ERR_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_frame_cnt
);

    localparam int unsigned WORD_W = 10;
    localparam int unsigned WCNT_W = (PRBS_LENGTH > 1) ? $clog2(PRBS_LENGTH) : 1;
    localparam int unsigned POP_W  = 4;
    localparam int unsigned SUM_W  = ERR_W + 1;

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        CHECK_PRBS = 2'd1,
        CHECK_TAIL = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic [POLY_LENGHT-1:0] lfsr, lfsr_d, lfsr_step, lfsr_tmp;
    logic [WCNT_W-1:0]      wcnt, wcnt_d;
    logic [ERR_W-1:0]       acc, acc_d, acc_sat;
    logic [SUM_W-1:0]       acc_sum;
    logic [WORD_W-1:0]      exp_word, diff;
    logic [POP_W-1:0]       pop;
    logic                   fb;
    logic                   tail_bad;
    logic                   frame_done_d, frame_err_d, tail_err_d;
    logic [ERR_W-1:0]       bit_err_cnt_d;
    logic [CNT_W-1:0]       frame_cnt_d, err_frame_cnt_d;

    // Frame in progress: between HEAD detect and TAIL sample
    assign in_frame = (state == CHECK_PRBS) || (state == CHECK_TAIL);

    // Expected word from the current LFSR (10 serial steps) and the advanced LFSR
    always_comb begin
        lfsr_tmp = lfsr;
        exp_word = '0;
        fb       = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            fb          = lfsr_tmp[POLY_LENGHT-1] ^ lfsr_tmp[POLY_TAP-1];
            lfsr_tmp    = {lfsr_tmp[POLY_LENGHT-2:0], fb};
            exp_word[i] = fb;
        end
        lfsr_step = lfsr_tmp;
    end

    // Bit-error count of the current word and saturating accumulation
    always_comb begin
        diff = data_in ^ exp_word;
        pop  = '0;
        for (int i = 0; i < WORD_W; i++) begin
            pop = pop + POP_W'(diff[i]);
        end
        acc_sum = {1'b0, acc} + SUM_W'(pop);
        acc_sat = acc_sum[ERR_W] ? {ERR_W{1'b1}} : acc_sum[ERR_W-1:0];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d         = state;
        lfsr_d          = lfsr;
        wcnt_d          = wcnt;
        acc_d           = acc;
        tail_bad        = 1'b0;
        frame_done_d    = 1'b0;
        frame_err_d     = frame_err;
        tail_err_d      = tail_err;
        bit_err_cnt_d   = bit_err_cnt;
        frame_cnt_d     = frame_cnt;
        err_frame_cnt_d = err_frame_cnt;

        if (!check_enable) begin
            // Abort: partial frame is dropped without touching results
            state_d = HUNT;
        end else begin
            case (state)
                HUNT: begin
                    if (data_in == COMMA) begin
                        state_d = CHECK_PRBS;
                        lfsr_d  = PRBS_SEED;
                        wcnt_d  = '0;
                        acc_d   = '0;
                    end
                end
                CHECK_PRBS: begin
                    acc_d  = acc_sat;
                    lfsr_d = lfsr_step;
                    wcnt_d = wcnt + WCNT_W'(1);
                    if (wcnt == WCNT_W'(PRBS_LENGTH - 1)) begin
                        state_d = CHECK_TAIL;
                    end
                end
                CHECK_TAIL: begin
                    tail_bad      = (data_in != COMMA);
                    state_d       = HUNT;
                    frame_done_d  = 1'b1;
                    tail_err_d    = tail_bad;
                    frame_err_d   = (acc != '0) || tail_bad;
                    bit_err_cnt_d = acc;
                    if (!(&frame_cnt)) begin
                        frame_cnt_d = frame_cnt + CNT_W'(1);
                    end
                    if (frame_err_d && !(&err_frame_cnt)) begin
                        err_frame_cnt_d = err_frame_cnt + CNT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State, datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HUNT;
            lfsr          <= PRBS_SEED;
            wcnt          <= '0;
            acc           <= '0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            tail_err      <= 1'b0;
            bit_err_cnt   <= '0;
            frame_cnt     <= '0;
            err_frame_cnt <= '0;
        end else begin
            state         <= state_d;
            lfsr          <= lfsr_d;
            wcnt          <= wcnt_d;
            acc           <= acc_d;
            frame_done    <= frame_done_d;
            frame_err     <= frame_err_d;
            tail_err      <= tail_err_d;
            bit_err_cnt   <= bit_err_cnt_d;
            frame_cnt     <= frame_cnt_d;
            err_frame_cnt <= err_frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_data_check.sv
// Bench for data_check: directed frames plus randomized traffic, checked every
// cycle against a frame-level model. A second instance with narrow counters
// runs on the same stimulus to exercise saturation.
module tb_data_check;

    localparam int unsigned L     = 8;
    localparam logic [9:0]  COMMA = 10'b1100110011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       check_enable;
    logic [9:0] data_in;

    logic        in_frame, frame_done, frame_err, tail_err;
    logic [9:0]  bit_err_cnt;
    logic [15:0] frame_cnt, err_frame_cnt;

    logic        in_frame_s, frame_done_s, frame_err_s, tail_err_s;
    logic [3:0]  bit_err_cnt_s;
    logic [1:0]  frame_cnt_s, err_frame_cnt_s;

    data_check dut (
        .clk(clk), .rst_n(rst_n), .check_enable(check_enable), .data_in(data_in),
        .in_frame(in_frame), .frame_done(frame_done), .frame_err(frame_err),
        .tail_err(tail_err), .bit_err_cnt(bit_err_cnt), .frame_cnt(frame_cnt),
        .err_frame_cnt(err_frame_cnt)
    );

    data_check #(.ERR_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .check_enable(check_enable), .data_in(data_in),
        .in_frame(in_frame_s), .frame_done(frame_done_s), .frame_err(frame_err_s),
        .tail_err(tail_err_s), .bit_err_cnt(bit_err_cnt_s), .frame_cnt(frame_cnt_s),
        .err_frame_cnt(err_frame_cnt_s)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] golden   [L];
    logic [9:0] err_mask [L];
    bit         pbits    [9 + 10*L];

    // Model of what the outputs should show after the next active edge
    logic exp_done, exp_in, exp_ferr, exp_terr;
    int   exp_errs, n_frames, n_err_frames;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic check_all();
        chk("frame_done",      32'(frame_done),      32'(exp_done));
        chk("in_frame",        32'(in_frame),        32'(exp_in));
        chk("frame_err",       32'(frame_err),       32'(exp_ferr));
        chk("tail_err",        32'(tail_err),        32'(exp_terr));
        chk("bit_err_cnt",     32'(bit_err_cnt),     32'(sat(exp_errs, 10)));
        chk("frame_cnt",       32'(frame_cnt),       32'(sat(n_frames, 16)));
        chk("err_frame_cnt",   32'(err_frame_cnt),   32'(sat(n_err_frames, 16)));
        chk("sat_frame_done",  32'(frame_done_s),    32'(exp_done));
        chk("sat_bit_err_cnt", 32'(bit_err_cnt_s),   32'(sat(exp_errs, 4)));
        chk("sat_frame_cnt",   32'(frame_cnt_s),     32'(sat(n_frames, 2)));
        chk("sat_err_frames",  32'(err_frame_cnt_s), 32'(sat(n_err_frames, 2)));
    endtask

    task automatic model_reset();
        exp_done = 0; exp_in = 0; exp_ferr = 0; exp_terr = 0;
        exp_errs = 0; n_frames = 0; n_err_frames = 0;
    endtask

    // One word per cycle: check what the previous edge produced, then drive
    task automatic drive(input logic [9:0] w, input logic en, input logic nxt_in,
                         input logic is_tail, input int errs);
        @(negedge clk);
        check_all();
        data_in      = w;
        check_enable = en;
        exp_in       = nxt_in;
        exp_done     = is_tail;
        if (is_tail) begin
            exp_terr = (w != COMMA);
            exp_ferr = (errs != 0) || exp_terr;
            exp_errs = errs;
            n_frames++;
            if (exp_ferr) n_err_frames++;
        end
    endtask

    function automatic logic [9:0] rand_idle();
        logic [9:0] w;
        do w = 10'($urandom); while (w == COMMA);
        return w;
    endfunction

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(rand_idle(), 1'($urandom), 1'b0, 1'b0, 0);
    endtask

    task automatic clear_masks();
        for (int i = 0; i < L; i++) err_mask[i] = '0;
    endtask

    // Positions: 0 = HEAD, 1..L = PRBS words, L+1 = TAIL. abort_at < 0 = no abort.
    task automatic send_frame(input logic [9:0] tail, input int abort_at, input bit use_rst);
        int errs;
        errs = 0;
        for (int p = 0; p <= L + 1; p++) begin
            if (p == abort_at) begin
                if (use_rst) begin
                    @(negedge clk);
                    check_all();
                    rst_n        = 1'b0;
                    check_enable = 1'b1;
                    data_in      = rand_idle();
                    #1;
                    model_reset();
                    check_all();
                    #3 rst_n = 1'b1;
                end else begin
                    drive(10'($urandom), 1'b0, 1'b0, 1'b0, 0);
                end
                return;
            end
            if (p == 0) begin
                drive(COMMA, 1'b1, 1'b1, 1'b0, 0);
            end else if (p <= L) begin
                errs += $countones(err_mask[p-1]);
                drive(golden[p-1] ^ err_mask[p-1], 1'b1, 1'b1, 1'b0, 0);
            end else begin
                drive(tail, 1'b1, 1'b0, 1'b1, errs);
            end
        end
    endtask

    initial begin
        // Golden PRBS as a bit recurrence: b[n] = b[n-9] ^ b[n-5], seeded with 9'h1FF
        for (int j = 0; j < 9; j++) pbits[j] = 1'b1;
        for (int n = 9; n < 9 + 10*L; n++) pbits[n] = pbits[n-9] ^ pbits[n-5];
        for (int w = 0; w < L; w++)
            for (int i = 0; i < 10; i++) golden[w][i] = pbits[9 + 10*w + i];

        rst_n = 1'b0; check_enable = 1'b0; data_in = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        gap(2);

        // Clean frame
        clear_masks();
        send_frame(COMMA, -1, 0);
        gap(2);

        // 3 flipped bits in one word, 1 in another
        err_mask[2] = 10'b0000010101;
        err_mask[7] = 10'b1000000000;
        send_frame(COMMA, -1, 0);
        gap(1);

        // Bad tail
        clear_masks();
        send_frame(10'h000, -1, 0);
        gap(1);

        // Back-to-back frames
        for (int k = 0; k < 5; k++) send_frame(COMMA, -1, 0);
        gap(2);

        // Enable dropped mid-frame, then a clean frame
        send_frame(COMMA, 4, 0);
        gap(2);
        send_frame(COMMA, -1, 0);
        gap(2);

        // Reset mid-frame, then a clean frame
        send_frame(COMMA, 4, 1);
        gap(2);
        send_frame(COMMA, -1, 0);
        gap(2);

        // Errored frames past the narrow counters' limit, plus one heavy frame
        clear_masks();
        err_mask[0] = 10'h001;
        for (int k = 0; k < 5; k++) send_frame(COMMA, -1, 0);
        for (int i = 0; i < L; i++) err_mask[i] = 10'h3FF;
        send_frame(COMMA, -1, 0);
        gap(1);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            logic [9:0] tail;
            int         abort_at;
            clear_masks();
            if ($urandom_range(0, 2) == 0)
                for (int i = 0; i < L; i++)
                    if ($urandom_range(0, 3) == 0) err_mask[i] = 10'($urandom);
            tail     = ($urandom_range(0, 4) == 0) ? rand_idle() : COMMA;
            abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, L + 1)) : -1;
            send_frame(tail, abort_at, ($urandom_range(0, 9) == 0));
            gap($urandom_range(0, 3));
        end
        gap(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
